// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: state codes,
// opcode/funct values, ALU operation codes and datapath mux selects.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_NOR = 6'b100111;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    localparam logic [1:0] PCSRC_ALURES = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b11;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

endpackage

// File: rtl/alu_decoder.sv
// R-type funct to ALU operation decoder. Unknown or non-qualified funct
// yields ADD with known_o low so the FSM can raise an exception.
module alu_decoder
    import ctrl_pkg::*;
(
    input  logic [5:0] funct_i,
    input  logic       valid_i,
    output logic [3:0] alu_ctrl_o,
    output logic       known_o
);

    always_comb begin
        alu_ctrl_o = ALU_ADD;
        known_o    = 1'b0;
        if (valid_i) begin
            known_o = 1'b1;
            case (funct_i)
                FN_ADD:  alu_ctrl_o = ALU_ADD;
                FN_SUB:  alu_ctrl_o = ALU_SUB;
                FN_AND:  alu_ctrl_o = ALU_AND;
                FN_OR:   alu_ctrl_o = ALU_OR;
                FN_SLT:  alu_ctrl_o = ALU_SLT;
                FN_NOR:  alu_ctrl_o = ALU_NOR;
                default: known_o    = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for the multicycle MIPS datapath; drives all mux
// selects, enables and ALU opcode, and flags illegal ops / signed overflow.
module multicycle_control
    import ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction,
    input  logic        overflow,
    output logic [1:0]  PCSource,
    output logic [1:0]  ALUSrcB,
    output logic        ALUSrcA,
    output logic        RegWrite,
    output logic        RegDst,
    output logic        PCWriteCond,
    output logic        PCWrite,
    output logic        IorD,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        MemToReg,
    output logic        IRWrite,
    output logic [3:0]  ALUControl,
    output logic [3:0]  state,
    output logic        exception
);

    state_t     state_q, state_d;
    logic       exc_q, exc_d;
    logic [5:0] opcode, funct;
    logic [3:0] dec_alu;
    logic       dec_known;
    logic       unused_instr;

    assign opcode       = instruction[31:26];
    assign funct        = instruction[5:0];
    assign unused_instr = ^instruction[25:6];

    alu_decoder u_alu_decoder (
        .funct_i    (funct),
        .valid_i    (state_q == S_EXEC),
        .alu_ctrl_o (dec_alu),
        .known_o    (dec_known)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            exc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            exc_q   <= exc_d;
        end
    end

    always_comb begin
        state_d     = S_FETCH;
        exc_d       = 1'b0;
        PCSource    = PCSRC_ALURES;
        ALUSrcB     = SRCB_B;
        ALUSrcA     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        PCWriteCond = 1'b0;
        PCWrite     = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemToReg    = 1'b0;
        IRWrite     = 1'b0;
        ALUControl  = ALU_AND;
        case (state_q)
            S_FETCH: begin
                MemRead    = 1'b1;
                IRWrite    = 1'b1;
                ALUSrcB    = SRCB_FOUR;
                ALUControl = ALU_ADD;
                PCWrite    = 1'b1;
                state_d    = S_DECODE;
            end
            S_DECODE: begin
                // Branch target is computed speculatively into ALUOut here.
                ALUSrcB    = SRCB_IMMSH;
                ALUControl = ALU_ADD;
                case (opcode)
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      exc_d   = 1'b1;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = SRCB_IMM;
                ALUControl = ALU_ADD;
                state_d    = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemToReg = 1'b1;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_EXEC: begin
                ALUSrcA    = 1'b1;
                ALUControl = dec_alu;
                // Signed overflow on add/sub suppresses the writeback.
                if (!dec_known || (overflow && (funct == FN_ADD || funct == FN_SUB))) begin
                    exc_d = 1'b1;
                end else begin
                    state_d = S_ALUWB;
                end
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUControl  = ALU_SUB;
                PCWriteCond = 1'b1;
                PCSource    = PCSRC_ALUOUT;
            end
            S_ADDIEX: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = SRCB_IMM;
                ALUControl = ALU_ADD;
                if (overflow) begin
                    exc_d = 1'b1;
                end else begin
                    state_d = S_ADDIWB;
                end
            end
            S_ADDIWB: begin
                RegWrite = 1'b1;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = PCSRC_JUMP;
            end
            default: state_d = S_FETCH;
        endcase
    end

    assign state     = state_q;
    assign exception = exc_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: a per-instruction reference model
// queues the expected per-cycle control word, a monitor pops and compares.
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instruction = 32'h0;
    logic        overflow = 1'b0;
    logic [1:0]  PCSource, ALUSrcB;
    logic        ALUSrcA, RegWrite, RegDst, PCWriteCond, PCWrite, IorD;
    logic        MemRead, MemWrite, MemToReg, IRWrite, exception;
    logic [3:0]  ALUControl, state;

    multicycle_control dut (
        .clk(clk), .rst(rst), .instruction(instruction), .overflow(overflow),
        .PCSource(PCSource), .ALUSrcB(ALUSrcB), .ALUSrcA(ALUSrcA),
        .RegWrite(RegWrite), .RegDst(RegDst), .PCWriteCond(PCWriteCond),
        .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
        .MemToReg(MemToReg), .IRWrite(IRWrite), .ALUControl(ALUControl),
        .state(state), .exception(exception)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic [1:0] pcs;
        logic [1:0] srcb;
        logic       srca, rw, rdst, pwc, pw, iord, mr, mw, m2r, irw;
        logic [3:0] aluc;
        logic       exc;
    } ctl_t;

    ctl_t expq[$];
    int   compared = 0;
    int   mismatched = 0;
    logic pend_exc = 1'b0;

    function automatic logic [3:0] exec_alu(input logic [5:0] fn);
        case (fn)
            6'h20:   return 4'b0010;
            6'h22:   return 4'b0110;
            6'h24:   return 4'b0000;
            6'h25:   return 4'b0001;
            6'h2A:   return 4'b0111;
            6'h27:   return 4'b1100;
            default: return 4'b0010;
        endcase
    endfunction

    function automatic bit fn_known(input logic [5:0] fn);
        return fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27};
    endfunction

    // Expected control word of one named step of an instruction.
    function automatic ctl_t ctl_of(input int s, input logic [5:0] fn, input logic exc);
        ctl_t c;
        c     = '0;
        c.st  = s[3:0];
        c.exc = exc;
        case (s)
            0:  begin c.mr = 1; c.irw = 1; c.srcb = 2'b01; c.aluc = 4'b0010; c.pw = 1; end
            1:  begin c.srcb = 2'b11; c.aluc = 4'b0010; end
            2:  begin c.srca = 1; c.srcb = 2'b10; c.aluc = 4'b0010; end
            3:  begin c.mr = 1; c.iord = 1; end
            4:  begin c.rw = 1; c.m2r = 1; end
            5:  begin c.mw = 1; c.iord = 1; end
            6:  begin c.srca = 1; c.aluc = exec_alu(fn); end
            7:  begin c.rw = 1; c.rdst = 1; end
            8:  begin c.srca = 1; c.aluc = 4'b0110; c.pwc = 1; c.pcs = 2'b01; end
            9:  begin c.srca = 1; c.srcb = 2'b10; c.aluc = 4'b0010; end
            10: begin c.rw = 1; end
            11: begin c.pw = 1; c.pcs = 2'b11; end
            default: ;
        endcase
        return c;
    endfunction

    // Called one time unit after a rising edge with the DUT in FETCH.
    task automatic issue(input logic [31:0] ins, input logic ov, input int maxc);
        int         seq[$];
        logic       fault;
        int         n;
        logic [5:0] op;
        logic [5:0] fn;
        op    = ins[31:26];
        fn    = ins[5:0];
        seq   = {0, 1};
        fault = 1'b0;
        case (op)
            6'h00: begin
                seq.push_back(6);
                if (!fn_known(fn) || (ov && (fn == 6'h20 || fn == 6'h22))) fault = 1'b1;
                else seq.push_back(7);
            end
            6'h23: begin seq.push_back(2); seq.push_back(3); seq.push_back(4); end
            6'h2B: begin seq.push_back(2); seq.push_back(5); end
            6'h04: seq.push_back(8);
            6'h08: begin
                seq.push_back(9);
                if (ov) fault = 1'b1;
                else seq.push_back(10);
            end
            6'h02: seq.push_back(11);
            default: fault = 1'b1;
        endcase
        n = (seq.size() < maxc) ? seq.size() : maxc;
        instruction = ins;
        overflow    = ov;
        for (int i = 0; i < n; i++)
            expq.push_back(ctl_of(seq[i], fn, (i == 0) ? pend_exc : 1'b0));
        pend_exc = (n == seq.size()) ? fault : 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        ctl_t e, a;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            a = {state, PCSource, ALUSrcB, ALUSrcA, RegWrite, RegDst, PCWriteCond,
                 PCWrite, IorD, MemRead, MemWrite, MemToReg, IRWrite, ALUControl, exception};
            compared++;
            if (a !== e) begin
                mismatched++;
                $display("FAIL cycle t=%0t instr=%h ov=%0b: got state=%0d ctl=%h, expected state=%0d ctl=%h",
                         $time, instruction, overflow, a.st, a, e.st, e);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    logic [31:0] dir_ins[11] = '{32'h00221820, 32'h8C220004, 32'hAC220008, 32'h10220003,
                                 32'h08000010, 32'h20220005, 32'h20220005, 32'hFC000000,
                                 32'h00221821, 32'h00221822, 32'h00221824};
    logic        dir_ov[11]  = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1};
    logic [5:0]  kfn[6]      = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27};

    initial begin
        logic [31:0] r, ins;
        logic [5:0]  op, fn;
        ctl_t        a;
        #2;
        a = {state, PCSource, ALUSrcB, ALUSrcA, RegWrite, RegDst, PCWriteCond,
             PCWrite, IorD, MemRead, MemWrite, MemToReg, IRWrite, ALUControl, exception};
        check("reset_outputs", 32'(a), 32'(ctl_of(0, 6'h0, 1'b0)));
        @(posedge clk); #1 rst = 1'b0;

        for (int i = 0; i < 11; i++) issue(dir_ins[i], dir_ov[i], 99);

        // Reset in the middle of a load, with an exception still pending.
        issue(32'hFC000000, 1'b0, 99);
        issue(32'h8C220004, 1'b0, 3);
        @(negedge clk);
        check("pre_reset_state", 32'(state), 32'd3);
        check("pre_reset_memrd", {30'd0, MemRead, IorD}, 32'd3);
        #1 rst = 1'b1;
        #1;
        check("async_reset_state", 32'(state), 32'd0);
        check("async_reset_exc", 32'(exception), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_no_writes", {30'd0, MemWrite, RegWrite}, 32'd0);
        end
        @(posedge clk); #1 rst = 1'b0;
        pend_exc = 1'b0;
        issue(32'hFC000000, 1'b0, 99);
        issue(32'h00221820, 1'b0, 99);

        for (int k = 0; k < 300; k++) begin
            r = $urandom;
            case ($urandom_range(0, 7))
                0: ins = {6'h00, r[25:6], kfn[$urandom_range(0, 5)]};
                1: begin
                    fn = 6'h20;
                    while (fn_known(fn)) fn = 6'($urandom_range(0, 63));
                    ins = {6'h00, r[25:6], fn};
                end
                2: ins = {6'h23, r[25:0]};
                3: ins = {6'h2B, r[25:0]};
                4: ins = {6'h04, r[25:0]};
                5: ins = {6'h02, r[25:0]};
                6: ins = {6'h08, r[25:0]};
                default: begin
                    op = 6'h00;
                    while (op inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02})
                        op = 6'($urandom_range(0, 63));
                    ins = {op, r[25:0]};
                end
            endcase
            issue(ins, ($urandom_range(0, 2) == 0), 99);
        end

        issue(32'h00221820, 1'b0, 99);
        check("queue_drained", 32'(expq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Main control unit for the multicycle MIPS datapath. A Moore FSM sequences fetch, decode, execute, memory and writeback by driving every datapath mux select, enable and ALU opcode. It decodes the IR contents (instruction) and uses the datapath overflow flag. It sits beside the datapath in the CPU top level, with no other logic between them.

Parameters:
none (all encodings fixed in ctrl_pkg)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
instruction  in  32  IR contents; opcode=[31:26], funct=[5:0]
overflow  in  1  ALU overflow, combinational, current cycle
PCSource  out  2  00 ALUResult, 01 ALUOut, 10 ALUOut, 11 jump target
ALUSrcB  out  2  00 B, 01 const 4, 10 SignImm, 11 SignImm<<2
ALUSrcA  out  1  0 PC, 1 A
RegWrite  out  1  regfile write enable
RegDst  out  1  0 rt, 1 rd
PCWriteCond  out  1  PC write if Zero
PCWrite  out  1  unconditional PC write
IorD  out  1  0 PC, 1 ALUOut as memory address
MemRead  out  1  memory read
MemWrite  out  1  memory write
MemToReg  out  1  0 ALUOut, 1 Data
IRWrite  out  1  IR load
ALUControl  out  4  AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100
state  out  4  current state code, debug
exception  out  1  1-cycle pulse: illegal opcode or signed overflow

Behaviour:
- rst asserted: state=FETCH and exception=0 asynchronously. Outputs equal the FETCH decode, which is harmless because the datapath is also held in reset.
- Outputs are pure functions of the state. The only exception is ALUControl in EXEC, which also depends on funct. Any signal not listed for a state is 0, and its selects are 00/0.
- FETCH(0): MemRead=1, IRWrite=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUControl=ADD, PCSource=00, PCWrite=1. Next state: DECODE.
- DECODE(1): ALUSrcA=0, ALUSrcB=11, ALUControl=ADD, so the branch target goes to ALUOut. Next state by opcode:
  - 000000 -> EXEC
  - 100011 or 101011 -> MEMADR
  - 000100 -> BRANCH
  - 001000 -> ADDIEX
  - 000010 -> JUMP
  - other -> FETCH with exception=1 for the next cycle
- MEMADR(2): ALUSrcA=1, ALUSrcB=10, ADD. Next: lw -> MEMRD, sw -> MEMWR.
- MEMRD(3): MemRead=1, IorD=1. Next: MEMWB.
- MEMWB(4): RegWrite=1, RegDst=0, MemToReg=1. Next: FETCH.
- MEMWR(5): MemWrite=1, IorD=1. Next: FETCH.
- EXEC(6): ALUSrcA=1, ALUSrcB=00, ALUControl from funct: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT, 100111 NOR.
  - Unknown funct: ALUControl=ADD, next FETCH, exception pulse.
  - overflow=1 with funct ADD/SUB: next FETCH, exception pulse, no writeback.
  - Otherwise next: ALUWB.
- ALUWB(7): RegWrite=1, RegDst=1, MemToReg=0. Next: FETCH.
- BRANCH(8): ALUSrcA=1, ALUSrcB=00, SUB, PCWriteCond=1, PCSource=01. Next: FETCH.
- ADDIEX(9): ALUSrcA=1, ALUSrcB=10, ADD. overflow=1: next FETCH with exception pulse. Otherwise next: ADDIWB.
- ADDIWB(10): RegWrite=1, RegDst=0, MemToReg=0. Next: FETCH.
- JUMP(11): PCWrite=1, PCSource=11. Next: FETCH.
- Codes 12-15 are unreachable and must recover to FETCH with no side effects.
- Latency in cycles, FETCH through the last state: R-type 4, lw 5, sw 4, beq 3, j 3, addi 4.
- exception is registered. It is high only during the FETCH cycle that follows the faulting state.
- rst asserted mid-instruction aborts the instruction; no write-enable is asserted after reset asserts.

Decomposition:
- ctrl_pkg: state codes, opcode and funct constants, ALUControl codes, PCSource/ALUSrcB select codes.
- Sub-module alu_decoder, combinational: (funct, valid flag) -> ALUControl.
- The state register and next-state/output logic stay in multicycle_control.

Test Plan:
- rst pulse mid-MEMRD -> state=0 immediately, exception=0, MemWrite/RegWrite never asserted afterwards.
- instruction=0x00221820 (add $3,$1,$2), overflow=0 -> states 0,1,6,7. EXEC: ALUControl=0010, ALUSrcA=1, ALUSrcB=00. ALUWB: RegWrite=1, RegDst=1.
- 0x8C220004 (lw) -> states 0,1,2,3,4. MEMRD: IorD=1, MemRead=1. MEMWB: MemToReg=1, RegDst=0. Then 0xAC220008 (sw) -> 0,1,2,5 with MemWrite=1 for exactly one cycle.
- 0x10220003 (beq) -> states 0,1,8 with PCWriteCond=1, PCSource=01, ALUControl=0110. Then 0x08000010 (j) -> 0,1,11 with PCWrite=1, PCSource=11.
- 0x20220005 (addi): overflow=0 -> 0,1,9,10 with RegWrite=1 in ADDIWB. overflow=1 in state 9 -> 0,1,9,0 with no RegWrite and exception=1 in the following FETCH.
- 0xFC000000 (illegal opcode), and 0x00221821 (unknown funct) -> return to FETCH, exception pulse one cycle, no RegWrite/MemWrite/PCWriteCond.
